// File: rtl/pulse_gen.sv
// Single-shot pulse generator: ready after a post-reset delay, then one
// delayed, fixed-width pulse per rising edge of start.
module pulse_gen #(
  parameter int RESET_DELAY = 5,
  parameter int START_DELAY = 3,
  parameter int PULSE_WIDTH = 4,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic pulse_out,
  output logic pulse_generator_ready_after_reset
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if (RESET_DELAY < 1 || RESET_DELAY > CNT_MAX) begin : g_bad_rd
    $error("pulse_gen: RESET_DELAY out of range");
  end
  if (START_DELAY < 1 || START_DELAY > CNT_MAX) begin : g_bad_sd
    $error("pulse_gen: START_DELAY out of range");
  end
  if (PULSE_WIDTH < 1 || PULSE_WIDTH > CNT_MAX) begin : g_bad_pw
    $error("pulse_gen: PULSE_WIDTH out of range");
  end

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_DELAY - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PULSE_WIDTH - 1);

  typedef enum logic [1:0] {
    WAIT_RST,
    IDLE,
    DELAY,
    ACTIVE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             ready_q, ready_d;
  logic             start_q;
  logic             start_edge;

  assign start_edge = start & ~start_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    ready_d = ready_q;
    unique case (state_q)
      WAIT_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (start_edge) begin
          state_d = DELAY;
          cnt_d   = '0;
        end
      end
      DELAY: begin
        if (cnt_q == DLY_LAST) begin
          state_d = ACTIVE;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (cnt_q == PW_LAST) begin
          state_d = IDLE;
          pulse_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = WAIT_RST;
        cnt_d   = '0;
        pulse_d = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_RST;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      ready_q <= ready_d;
      start_q <= start;
    end
  end

  assign pulse_out = pulse_q;
  assign pulse_generator_ready_after_reset = ready_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: default build plus an all-ones build, checked
// against vector tables and a time-window reference model.
module tb_pulse_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic p0, r0, p1, r1;

  always #5 clk = ~clk;

  pulse_gen dut0 (
    .clk(clk), .reset(reset), .start(start),
    .pulse_out(p0),
    .pulse_generator_ready_after_reset(r0)
  );

  pulse_gen #(
    .RESET_DELAY(1), .START_DELAY(1),
    .PULSE_WIDTH(1), .CNT_W(16)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .pulse_out(p1),
    .pulse_generator_ready_after_reset(r1)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model: everything expressed as edge-index windows
  longint rd [2] = '{5, 1};
  longint sd [2] = '{3, 1};
  longint pw [2] = '{4, 1};
  longint n = 0;
  longint last_rst [2] = '{0, 0};
  longint s_edge [2] = '{-1000000, -1000000};
  bit prev_start = 1'b0;
  bit exp_p [2];
  bit exp_r [2];
  int pulses0 = 0;
  int pulses1 = 0;
  bit last_p0 = 1'b0;
  bit last_p1 = 1'b0;

  task automatic chk(input string name, input logic act, input bit exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, n, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s);
    n++;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        last_rst[i] = n;
        s_edge[i] = -1000000;
      end else if (s && !prev_start &&
                   n >= last_rst[i] + rd[i] + 1 &&
                   n >= s_edge[i] + sd[i] + pw[i] + 1) begin
        s_edge[i] = n;
      end
      exp_r[i] = !r && (n >= last_rst[i] + rd[i]);
      exp_p[i] = (n >= s_edge[i] + sd[i]) &&
                 (n <= s_edge[i] + sd[i] + pw[i] - 1);
    end
    prev_start = r ? 1'b0 : s;
  endtask

  // drive at negedge, clock, then check at the following negedge
  task automatic step(input bit r, input bit s);
    reset = r;
    start = s;
    @(posedge clk);
    model_edge(r, s);
    @(negedge clk);
    chk("pulse_out_def", p0, exp_p[0]);
    chk("ready_def", r0, exp_r[0]);
    chk("pulse_out_min", p1, exp_p[1]);
    chk("ready_min", r1, exp_r[1]);
    if (p0 && !last_p0) pulses0++;
    if (p1 && !last_p1) pulses1++;
    last_p0 = p0;
    last_p1 = p1;
  endtask

  typedef struct {
    bit r;
    bit s;
    bit p;
    bit rdy;
  } vec_t;

  vec_t vt [21];

  initial begin
    // default build: reset with start high, wait, pulse, ignored start,
    // back-to-back accept, then reset mid-pulse
    vt = '{
      '{1,0,0,0}, '{1,1,0,0}, '{0,1,0,0}, '{0,0,0,0}, '{0,0,0,0},
      '{0,0,0,0}, '{0,0,0,1}, '{0,1,0,1}, '{0,1,0,1}, '{0,0,0,1},
      '{0,0,1,1}, '{0,1,1,1}, '{0,0,1,1}, '{0,0,1,1}, '{0,0,0,1},
      '{0,1,0,1}, '{0,1,0,1}, '{0,0,0,1}, '{0,0,1,1}, '{1,0,0,0},
      '{0,1,0,0}
    };
    @(negedge clk);
    for (int i = 0; i < 21; i++) begin
      step(vt[i].r, vt[i].s);
      chk("tbl_pulse", p0, vt[i].p);
      chk("tbl_ready", r0, vt[i].rdy);
    end

    // reset held 10 cycles, ready must stay low exactly 5 periods
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      chk("hold_ready_low", r0, 1'b0);
    end
    step(1'b0, 1'b0);
    chk("hold_ready_high", r0, 1'b1);

    // start held 20 cycles after ready: exactly one pulse per build
    pulses0 = 0;
    pulses1 = 0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    chk("held_one_pulse_def", logic'(pulses0 == 1), 1'b1);
    chk("held_one_pulse_min", logic'(pulses1 == 1), 1'b1);

    // all-ones build: pulse one period after start edge, one cycle wide
    step(1'b0, 1'b1);
    chk("min_no_pulse_yet", p1, 1'b0);
    step(1'b0, 1'b0);
    chk("min_pulse_high", p1, 1'b1);
    step(1'b0, 1'b0);
    chk("min_pulse_low", p1, 1'b0);
    step(1'b1, 1'b1);
    chk("min_ready_rst", r1, 1'b0);
    step(1'b0, 1'b0);
    chk("min_ready_1", r1, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
- Synchronous single-shot pulse generator.
- After reset release it waits a fixed number of cycles, then asserts a ready flag.
- Once ready, a rising edge on start produces one pulse_out pulse. The pulse begins a fixed delay after the start edge and lasts a fixed width.
- Used as a timing/strobe source in the pulse_generator subsystem. All timings are integer clock cycles.

Parameters:
- RESET_DELAY, 5: cycles from reset release to ready assertion; legal range 1..2^16-1.
- START_DELAY, 3: cycles from the start edge being sampled to pulse_out rising; legal range 1..2^16-1.
- PULSE_WIDTH, 4: cycles pulse_out stays high; legal range 1..2^16-1.
- CNT_W, 16: internal counter width; must hold the largest of the three values above.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse request; rising-edge triggered, may be held high for any number of cycles.
- pulse_out  out  1  generated pulse, registered.
- pulse_generator_ready_after_reset  out  1  high once the post-reset delay has elapsed; registered.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high. While reset is sampled high:
  - pulse_out=0, pulse_generator_ready_after_reset=0;
  - state=WAIT_RST, counter=0, start_q (previous start sample)=0.
- Parameter checks: any parameter <1, or a value not fitting CNT_W, is an elaboration-time error (assertion).
- Start edge detect: start_edge = start & ~start_q. start_q is registered every cycle and cleared by reset.
- State machine, all registered outputs:
  - WAIT_RST: counter increments on each edge with reset low. On the edge where counter reaches RESET_DELAY-1, go to IDLE and set ready=1. Ready therefore rises exactly RESET_DELAY clock periods after the last edge on which reset was sampled high.
  - IDLE: on the edge where start_edge=1, go to DELAY with counter=0.
  - DELAY: counter increments. On the edge where counter reaches START_DELAY-1, go to ACTIVE, set pulse_out=1, counter=0. pulse_out thus rises START_DELAY periods after the edge sampling start_edge.
  - ACTIVE: counter increments. On the edge where counter reaches PULSE_WIDTH-1, go to IDLE and clear pulse_out. High time is exactly PULSE_WIDTH periods.
- Ready flag: stays 1 in IDLE, DELAY and ACTIVE until the next reset.
- Ignored start requests:
  - start edges in WAIT_RST, DELAY or ACTIVE are ignored, with no queuing;
  - start held high across the return to IDLE does not retrigger; a fresh 0→1 transition is required.
- Boundary conditions:
  - Reset mid-operation, in any state: the next edge forces the reset values. pulse_out drops immediately and the RESET_DELAY count restarts when reset is released.
  - Simultaneous reset and start: reset wins.
  - start high during reset is sampled into start_q as 0. If start is still high when IDLE is entered, start_q becomes 1 during WAIT_RST, so no pulse fires.
  - Minimum values (1): START_DELAY=1 gives pulse_out high on the edge after the start-edge sample. PULSE_WIDTH=1 gives a one-cycle pulse.
- Glitches: no combinational paths from inputs to outputs; outputs are glitch-free.

Test Plan:
- Reset held 10 cycles then released → ready low for exactly 5 clock periods (50 ns at 10 ns clk), then high and stays high; pulse_out stays 0.
- Release reset, wait for ready, raise start for 2 cycles → pulse_out rises exactly 3 periods (30 ns) after the start-edge sample and is high exactly 4 periods (40 ns); exactly one pulse.
- Start pulses during WAIT_RST, DELAY and ACTIVE → no extra pulses and no change to the running pulse timing; a later clean start edge in IDLE gives a normal pulse.
- Start held high continuously for 20 cycles after ready → exactly one pulse.
- Assert reset for 1 cycle while pulse_out=1 → pulse_out and ready go 0 on the next edge; ready reasserts 5 periods after release.
- Build with RESET_DELAY=START_DELAY=PULSE_WIDTH=1 → ready one period after release; pulse_out high for one cycle, one period after the start-edge sample.
